// File: rtl/settings_pkg.sv
// ----------------------------------------------------------------------------
// settings_pkg
//  Shared widths and constants for the 1-D convolution datapath. Also holds the
//  requantisation helpers (round half up, arithmetic shift, saturate) that the
//  result sink uses.
//  No ports.
// ----------------------------------------------------------------------------
package settings_pkg;

   localparam int DATA_SIZE       = 16;
   localparam int EXTRA_BITS      = 8;
   localparam int FULL_SIZE       = 2*DATA_SIZE + EXTRA_BITS;

   localparam int SINK_SHIFT      = 15;
   localparam int SINK_FIFO_DEPTH = 16;
   localparam int SINK_CNT_SIZE   = 16;

   typedef logic signed [FULL_SIZE-1:0] full_t;   // kernel result
   typedef logic signed [FULL_SIZE:0]   wide_t;   // one guard bit for the rounding add
   typedef logic signed [DATA_SIZE-1:0] sample_t; // requantised sample

   typedef struct packed {
      logic    sat;     // the value was clipped
      sample_t sample;
   } sat_result_t;

   localparam wide_t SAT_MAX = wide_t'((2**(DATA_SIZE-1)) - 1);
   localparam wide_t SAT_MIN = wide_t'(-(2**(DATA_SIZE-1)));

   // Round half up, then drop the fractional bits. The guard bit keeps the
   // rounding constant from overflowing at the positive extreme.
   function automatic wide_t round_shift(input full_t full, input int unsigned shift);
      wide_t half;
      wide_t r;
      half = '0;
      if (shift != 0) half = wide_t'(1) << (shift - 1);
      r = wide_t'(full) + half;
      return r >>> shift;
   endfunction

   // Clip to the signed DATA_SIZE range.
   function automatic sat_result_t saturate(input wide_t q);
      sat_result_t res;
      if (q > SAT_MAX) begin
         res.sat    = 1'b1;
         res.sample = sample_t'(SAT_MAX);
      end else if (q < SAT_MIN) begin
         res.sat    = 1'b1;
         res.sample = sample_t'(SAT_MIN);
      end else begin
         res.sat    = 1'b0;
         res.sample = sample_t'(q);
      end
      return res;
   endfunction

   // Whole requantisation in one call: {sat, sample}.
   function automatic sat_result_t sat_round(input full_t full, input int unsigned shift);
      return saturate(round_shift(full, shift));
   endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// ----------------------------------------------------------------------------
// sync_fifo_fwft
//  Single-clock first-word-fall-through FIFO with a registered output word.
//  Capacity is DEPTH samples counting the output register.
//  Ports
//   clk, reset_n   clock, asynchronous active-low reset (empties the FIFO)
//   push/push_data write request; ignored when full unless a pop happens too
//   pop            consumer ready; only acts while valid is high
//   data/valid     head of the FIFO, registered
//   full/empty     level == DEPTH / level == 0
//   level          samples held, including the output register
// ----------------------------------------------------------------------------
module sync_fifo_fwft #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         data,
   output logic                     valid,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [AW:0]      mem_count;
   logic             do_pop;
   logic             do_push;
   logic             load;

   assign mem_count = wr_ptr - rd_ptr;
   assign level     = mem_count + {{AW{1'b0}}, valid};
   assign full      = (level == (AW+1)'(DEPTH));
   assign empty     = (level == '0);

   assign do_pop  = pop & valid;
   // A pop in the same edge frees a slot, so a write at full still lands.
   assign do_push = push & (~full | do_pop);
   // Refill the output register whenever it is empty or being consumed.
   assign load    = (mem_count != '0) & (~valid | do_pop);

   // NOTE: the storage array has no reset; the pointers alone define which
   // entries are live, and leaving it out keeps it mappable to RAM.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

   // NOTE: sequential state is written with non-blocking assignments so every
   // register samples the pre-edge values of its neighbours.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         data   <= '0;
         valid  <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (load) begin
            data   <= mem[rd_ptr[AW-1:0]];
            valid  <= 1'b1;
            rd_ptr <= rd_ptr + (AW+1)'(1);
         end else if (do_pop) begin
            valid  <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/convol_result_sink.sv
// ----------------------------------------------------------------------------
// convol_result_sink
//  Downstream end of the 1-D convolution result stream. Requantises each
//  FULL_SIZE result to DATA_SIZE (round, shift, saturate), buffers it in a
//  FWFT FIFO and presents it on a valid/ready stream. The kernel cannot be
//  stalled, so samples arriving at a full FIFO are dropped and counted.
//  Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   input_data/_valid   kernel result and strobe (no backpressure)
//   clear               synchronous clear of counters and sticky flag
//   output_data/_valid  requantised sample stream (registered)
//   output_data_ready   consumer accepts
//   fifo_level          samples held, including the output register
//   overflow_sticky     set on any dropped sample
//   saturate_count      samples clipped by the saturator (saturating)
//   drop_count          samples lost to a full FIFO (saturating)
// ----------------------------------------------------------------------------
module convol_result_sink
   import settings_pkg::*;
#(
   parameter int SHIFT      = SINK_SHIFT,
   parameter int FIFO_DEPTH = SINK_FIFO_DEPTH,
   parameter int CNT_SIZE   = SINK_CNT_SIZE
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic signed [FULL_SIZE-1:0]   input_data,
   input  logic                          input_data_valid,
   input  logic                          clear,
   output logic signed [DATA_SIZE-1:0]   output_data,
   output logic                          output_data_valid,
   input  logic                          output_data_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow_sticky,
   output logic [CNT_SIZE-1:0]           saturate_count,
   output logic [CNT_SIZE-1:0]           drop_count
);

   // R1: rounded and shifted, still at full precision
   logic        r1_valid;
   wide_t       r1_q;
   // R2: saturated sample
   sat_result_t r2_next;
   logic        r2_valid;
   sample_t     r2_sample;

   logic        sat_event;
   logic        drop_event;
   logic        fifo_full;
   logic        fifo_empty;
   logic        fifo_pop;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r1_valid <= 1'b0;
         r1_q     <= '0;
      end else begin
         r1_valid <= input_data_valid;
         if (input_data_valid) r1_q <= round_shift(input_data, SHIFT);
      end
   end

   assign r2_next   = saturate(r1_q);
   assign sat_event = r1_valid & r2_next.sat;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r2_valid  <= 1'b0;
         r2_sample <= '0;
      end else begin
         r2_valid <= r1_valid;
         if (r1_valid) r2_sample <= r2_next.sample;
      end
   end

   // No pop request is issued against an empty buffer; the FIFO also
   // qualifies pop with its own valid, so ready is ignored while invalid.
   assign fifo_pop = output_data_ready & ~fifo_empty;

   sync_fifo_fwft #(
      .WIDTH (DATA_SIZE),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (r2_valid),
      .push_data (r2_sample),
      .pop       (fifo_pop),
      .data      (output_data),
      .valid     (output_data_valid),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level)
   );

   // A full FIFO still takes the sample when the head leaves on the same edge.
   assign drop_event = r2_valid & fifo_full & ~(output_data_valid & output_data_ready);

   // Counters stick at all ones; clear wins over a same-cycle increment.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         saturate_count  <= '0;
         drop_count      <= '0;
         overflow_sticky <= 1'b0;
      end else if (clear) begin
         saturate_count  <= '0;
         drop_count      <= '0;
         overflow_sticky <= 1'b0;
      end else begin
         if (sat_event && (saturate_count != '1)) saturate_count <= saturate_count + CNT_SIZE'(1);
         if (drop_event && (drop_count != '1))    drop_count     <= drop_count + CNT_SIZE'(1);
         if (drop_event)                          overflow_sticky <= 1'b1;
      end
   end

endmodule
